// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state type and width limits.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sub_state_t;

    // Smallest operand width the serial datapath supports.
    localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when the bits match and a borrow ripples in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell per clock.
// start/busy/done handshake; results hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import arith_pkg::*;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH) begin : g_width_check
        $error("serial_subtractor: WIDTH must be at least %0d", MIN_WIDTH);
    end

    sub_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic             d_bit;
    logic             br_next;

    // The single datapath cell always works on the current LSBs and borrow.
    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    // Control FSM plus operand/result shift registers and borrow flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= {d_bit, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // br is the borrow into the MSB, br_next the borrow out.
                        diff  <= {d_bit, res_sh[WIDTH-1:1]};
                        bout  <= br_next;
                        ovf   <= br ^ br_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

    localparam int NSTREAM = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] prev4 = '0;   // {diff, bout, ovf} expected to be held

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
        logic       ov;
        bit         scramble;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int w, input longint a, input longint b, input longint bin,
                                  output longint d, output longint bo, output longint ov);
        longint m, full, sa, sb, sr;
        m    = longint'(1) <<< w;
        full = a - b - bin;
        d    = full & (m - 1);
        bo   = (full < 0) ? 1 : 0;
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sr   = sa - sb - bin;
        ov   = (sr < -(m / 2) || sr > m / 2 - 1) ? 1 : 0;
    endfunction

    // One WIDTH=4 operation; entered and left #1 after a rising edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                       input logic [3:0] ed, input logic eb, input logic eo, input bit scr);
        int extra;
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("busy_after_accept", 64'(busy4), 64'(1));
        check("hold_at_start", 64'({diff4, bout4, ovf4}), 64'(prev4));
        for (int k = 1; k < 4; k++) begin
            if (scr) begin
                start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
            end
            @(posedge clk); #1;
            check("run_busy_done", 64'({busy4, done4}), 64'(2'b10));
            check("hold_in_run", 64'({diff4, bout4, ovf4}), 64'(prev4));
        end
        @(posedge clk); #1;
        start4 = 1'b0;
        check("done_edge_busy_done", 64'({busy4, done4}), 64'(2'b01));
        check("diff", 64'(diff4), 64'(ed));
        check("bout", 64'(bout4), 64'(eb));
        check("ovf", 64'(ovf4), 64'(eo));
        prev4 = {ed, eb, eo};
        @(posedge clk); #1;
        check("done_one_cycle", 64'({busy4, done4}), 64'(2'b00));
        check("hold_after_done", 64'({diff4, bout4, ovf4}), 64'(prev4));
        if (scr) begin
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (done4 || busy4) extra++;
            end
            check("no_extra_done", 64'(extra), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint ha4[NSTREAM], hb4[NSTREAM], hc4[NSTREAM];
        longint ha8[NSTREAM], hb8[NSTREAM], hc8[NSTREAM];
        longint ed, eb, eo;
        int last4, last8, cnt4, cnt8, nd;

        tbl[0] = '{4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b0011, 4'b1011, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0};

        // Reset state of both instances.
        #1;
        check("reset4", 64'({busy4, done4, diff4, bout4, ovf4}), 64'(0));
        check("reset8", 64'({busy8, done8, diff8, bout8, ovf8}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        foreach (tbl[i])
            op4(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].ov, tbl[i].scramble);

        // Abort two cycles into an operation: outputs clear immediately.
        a4 = 4'b1011; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_op", 64'({busy4, done4, diff4, bout4, ovf4}), 64'(0));
        prev4 = '0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done4 || busy4) nd++;
        end
        check("no_done_after_abort", 64'(nd), 64'(0));
        op4(4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);

        // start held high with fresh random operands every cycle, both widths.
        // Each result must match the operands seen WIDTH edges before done.
        last4 = -1; last8 = -1; cnt4 = 0; cnt8 = 0;
        for (int n = 0; n < NSTREAM; n++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom); start4 = 1'b1;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'b1;
            ha4[n] = longint'(a4); hb4[n] = longint'(b4); hc4[n] = longint'(bin4);
            ha8[n] = longint'(a8); hb8[n] = longint'(b8); hc8[n] = longint'(bin8);
            @(posedge clk); #1;
            if (done4) begin
                check("stream4_latency", 64'(n >= 4), 64'(1));
                if (n >= 4) begin
                    model(4, ha4[n-4], hb4[n-4], hc4[n-4], ed, eb, eo);
                    check("stream4_diff", 64'(diff4), ed);
                    check("stream4_bout", 64'(bout4), eb);
                    check("stream4_ovf", 64'(ovf4), eo);
                end
                // Accept edge follows the done edge, so dones are WIDTH+1 edges apart.
                if (last4 >= 0) check("stream4_gap", 64'(n - last4), 64'(5));
                last4 = n; cnt4++;
            end
            if (done8) begin
                check("stream8_latency", 64'(n >= 8), 64'(1));
                if (n >= 8) begin
                    model(8, ha8[n-8], hb8[n-8], hc8[n-8], ed, eb, eo);
                    check("stream8_diff", 64'(diff8), ed);
                    check("stream8_bout", 64'(bout8), eb);
                    check("stream8_ovf", 64'(ovf8), eo);
                end
                if (last8 >= 0) check("stream8_gap", 64'(n - last8), 64'(9));
                last8 = n; cnt8++;
            end
        end
        start4 = 1'b0; start8 = 1'b0;
        check("stream4_count", 64'(cnt4), 64'((NSTREAM - 1 - 4) / 5 + 1));
        check("stream8_count", 64'(cnt8), 64'((NSTREAM - 1 - 8) / 9 + 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
